sw_debouncer: RTL and testbench



---
 rtl/sw_debouncer_if.sv | 29 ++
 rtl/sw_debouncer.sv | 113 +++++++++++
 tb/tb_sw_debouncer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_debouncer_if.sv
// ============================================================================
// Module   : sw_debouncer_if
// Desc     : Register-window bus between the bridge and the switch debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sw_debouncer_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata
    );
endinterface

`default_nettype wire

// File: rtl/sw_debouncer.sv
// ============================================================================
// Module   : sw_debouncer
// Desc     : Per-bit synchroniser + counter debouncer with sticky W1C edge flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debouncer #(
    parameter int WIDTH   = 16,
    parameter int CNT_MAX = 100000,
    parameter int CNT_W   = 17
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic [WIDTH-1:0] sw_raw,
    sw_debouncer_if.slave         bus,
    output logic      [WIDTH-1:0] sw_stable,
    output logic                  irq
);
    localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]       C_ADDR_LEVEL = 2'd0;
    localparam logic [1:0]       C_ADDR_RISE  = 2'd1;
    localparam logic [1:0]       C_ADDR_FALL  = 2'd2;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic             r_irq;

    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_rise_set;
    logic [WIDTH-1:0] w_fall_set;
    logic [WIDTH-1:0] w_rise_clr;
    logic [WIDTH-1:0] w_fall_clr;
    logic             w_unused_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_raw;
            r_s2 <= r_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_accept[gi] = (r_s2[gi] != r_stable[gi]) && (r_cnt[gi] == C_CNT_LAST);
        end
    endgenerate

    // Any cycle where the synchronised input agrees with stable restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
                end
            end
        end
    end

    assign w_rise_set = w_accept & r_s2;
    assign w_fall_set = w_accept & ~r_s2;
    assign w_rise_clr = (bus.we && (bus.addr == C_ADDR_RISE)) ? bus.wdata[WIDTH-1:0] : '0;
    assign w_fall_clr = (bus.we && (bus.addr == C_ADDR_FALL)) ? bus.wdata[WIDTH-1:0] : '0;

    // Set is OR-ed in after the clear so a simultaneous edge keeps the flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rise <= '0;
            r_fall <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_rise <= (r_rise & ~w_rise_clr) | w_rise_set;
            r_fall <= (r_fall & ~w_fall_clr) | w_fall_set;
            r_irq  <= |(r_rise | r_fall);
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            C_ADDR_LEVEL: bus.rdata[WIDTH-1:0] = r_stable;
            C_ADDR_RISE:  bus.rdata[WIDTH-1:0] = r_rise;
            C_ADDR_FALL:  bus.rdata[WIDTH-1:0] = r_fall;
            default:      bus.rdata = '0;
        endcase
    end

    assign w_unused_wdata = ^bus.wdata;
    assign sw_stable      = r_stable;
    assign irq            = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_sw_debouncer.sv
// ============================================================================
// Module   : tb_sw_debouncer
// Desc     : Self-checking bench: directed sequences, bus table, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_debouncer;
    localparam int C_WIDTH   = 16;
    localparam int C_CNT_MAX = 4;
    localparam int C_CNT_W   = 3;

    logic                clk;
    logic                rstn;
    logic [C_WIDTH-1:0]  sw_raw;
    logic [C_WIDTH-1:0]  sw_stable;
    logic                irq;

    sw_debouncer_if bus_if ();

    sw_debouncer #(
        .WIDTH   (C_WIDTH),
        .CNT_MAX (C_CNT_MAX),
        .CNT_W   (C_CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_raw    (sw_raw),
        .bus       (bus_if.slave),
        .sw_stable (sw_stable),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stable flips once the last CNT_MAX synchronised samples
    // all disagree with it; the window restarts on every accept and on reset.
    logic [C_WIDTH-1:0] m_stable, m_rise, m_fall;
    logic               m_irq;
    logic [C_WIDTH-1:0] m_pipe[$];
    logic [C_WIDTH-1:0] m_hist[$];

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } bus_vec_t;

    bus_vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stable = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_irq    = 1'b0;
        m_pipe.delete();
        m_pipe.push_back('0);
        m_pipe.push_back('0);
        m_hist.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {16'h0, m_stable};
            2'd1:    return {16'h0, m_rise};
            2'd2:    return {16'h0, m_fall};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic [C_WIDTH-1:0] cur, new_stable, set_r, set_f, clr_r, clr_f;
        logic               all_differ;
        cur = m_pipe[0];
        void'(m_pipe.pop_front());
        m_pipe.push_back(sw_raw);
        m_hist.push_back(cur);
        if (m_hist.size() > C_CNT_MAX) void'(m_hist.pop_front());
        new_stable = m_stable;
        set_r = '0;
        set_f = '0;
        for (int b = 0; b < C_WIDTH; b++) begin
            all_differ = (m_hist.size() == C_CNT_MAX);
            foreach (m_hist[k]) if (m_hist[k][b] == m_stable[b]) all_differ = 1'b0;
            if (all_differ) begin
                new_stable[b] = cur[b];
                if (cur[b]) set_r[b] = 1'b1;
                else        set_f[b] = 1'b1;
            end
        end
        // A sample that causes an accept starts a fresh window.
        for (int b = 0; b < C_WIDTH; b++) begin
            if (new_stable[b] != m_stable[b]) begin
                foreach (m_hist[k]) m_hist[k][b] = new_stable[b];
            end
        end
        clr_r  = (bus_if.we && bus_if.addr == 2'd1) ? bus_if.wdata[15:0] : 16'h0;
        clr_f  = (bus_if.we && bus_if.addr == 2'd2) ? bus_if.wdata[15:0] : 16'h0;
        m_irq  = |(m_rise | m_fall);
        m_rise = (m_rise & ~clr_r) | set_r;
        m_fall = (m_fall & ~clr_f) | set_f;
        m_stable = new_stable;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("stable_vs_model", {16'h0, sw_stable}, {16'h0, m_stable});
        chk("irq_vs_model", {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.we    = 1'b1;
        bus_if.wdata = d;
        cycle();
        bus_if.we    = 1'b0;
        bus_if.wdata = '0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus_if.addr = a;
        #1;
        chk(name, bus_if.rdata, exp);
    endtask

    initial begin
        int hold;
        rstn         = 1'b0;
        sw_raw       = 16'hFFFF;
        bus_if.addr  = '0;
        bus_if.we    = 1'b0;
        bus_if.wdata = '0;
        model_reset();

        // Reset hold with all inputs high
        repeat (3) @(posedge clk);
        #1;
        rd_chk("rst_level", 2'd0, 32'h0);
        rd_chk("rst_rise", 2'd1, 32'h0);
        rd_chk("rst_fall", 2'd2, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rstn = 1'b1;
        cycles(5);
        chk("rel_stable_edge4", {16'h0, sw_stable}, 32'h0);
        cycle();
        chk("rel_stable_edge5", {16'h0, sw_stable}, 32'h0000FFFF);
        chk("rel_irq_edge5", {31'h0, irq}, 32'h0);
        rd_chk("rel_rise", 2'd1, 32'h0000FFFF);
        cycle();
        chk("rel_irq_edge6", {31'h0, irq}, 32'h1);
        wr(2'd1, 32'h0000FFFF);
        cycles(2);
        chk("clr_irq", {31'h0, irq}, 32'h0);

        // Glitch rejection on bit 3
        sw_raw = 16'h0000;
        cycles(10);
        wr(2'd2, 32'h0000FFFF);
        cycles(2);
        sw_raw = 16'h0008;
        cycles(3);
        sw_raw = 16'h0000;
        cycles(6);
        chk("glitch_stable", {16'h0, sw_stable}, 32'h0);
        rd_chk("glitch_rise", 2'd1, 32'h0);
        sw_raw = 16'h0008;
        cycles(10);
        chk("hold_stable", {16'h0, sw_stable}, 32'h8);
        rd_chk("hold_rise", 2'd1, 32'h8);

        // Press / release on bit 0
        wr(2'd1, 32'h0000FFFF);
        sw_raw = 16'h0009;
        cycles(10);
        sw_raw = 16'h0008;
        cycles(10);
        rd_chk("pr_rise", 2'd1, 32'h1);
        rd_chk("pr_fall", 2'd2, 32'h1);
        wr(2'd1, 32'h1);
        cycle();
        rd_chk("pr_rise_clr", 2'd1, 32'h0);
        rd_chk("pr_fall_kept", 2'd2, 32'h1);
        chk("pr_irq_kept", {31'h0, irq}, 32'h1);
        wr(2'd2, 32'h1);
        chk("pr_irq_lag", {31'h0, irq}, 32'h1);
        cycle();
        chk("pr_irq_off", {31'h0, irq}, 32'h0);

        // Clear RISE[5] on the exact edge bit 5 is accepted
        sw_raw = 16'h0028;
        cycles(5);
        chk("col_pre", {16'h0, sw_stable}, 32'h8);
        wr(2'd1, 32'h20);
        chk("col_accept", {16'h0, sw_stable}, 32'h28);
        rd_chk("col_rise", 2'd1, 32'h20);

        // Bus corner table: stable=0x28, rise=0x20, fall=0
        vecs[0]  = '{2'd0, 1'b1, 32'hFFFFFFFF, 32'h28};
        vecs[1]  = '{2'd3, 1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[2]  = '{2'd1, 1'b1, 32'h00000000, 32'h20};
        vecs[3]  = '{2'd1, 1'b0, 32'h00000000, 32'h20};
        vecs[4]  = '{2'd2, 1'b0, 32'h00000000, 32'h0};
        vecs[5]  = '{2'd0, 1'b0, 32'h00000000, 32'h28};
        vecs[6]  = '{2'd2, 1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[7]  = '{2'd1, 1'b1, 32'hFFFF0000, 32'h20};
        vecs[8]  = '{2'd1, 1'b0, 32'h00000000, 32'h20};
        vecs[9]  = '{2'd1, 1'b1, 32'h00000020, 32'h20};
        vecs[10] = '{2'd1, 1'b0, 32'h00000000, 32'h0};
        vecs[11] = '{2'd3, 1'b0, 32'h00000000, 32'h0};
        for (int i = 0; i < 12; i++) begin
            bus_if.addr  = vecs[i].addr;
            bus_if.we    = vecs[i].we;
            bus_if.wdata = vecs[i].wdata;
            #1;
            chk($sformatf("table_%0d", i), bus_if.rdata, vecs[i].exp_rdata);
            cycle();
        end
        bus_if.we    = 1'b0;
        bus_if.wdata = '0;

        // Reset mid-count on bit 7
        sw_raw = 16'h00A8;
        cycles(4);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_stable", {16'h0, sw_stable}, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        rd_chk("mid_rst_level", 2'd0, 32'h0);
        rstn = 1'b1;
        cycles(5);
        chk("mid_edge4", {16'h0, sw_stable}, 32'h0);
        cycle();
        chk("mid_edge5", {16'h0, sw_stable}, 32'hA8);
        rd_chk("mid_rise", 2'd1, 32'hA8);

        // Randomised traffic against the model
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 1) == 0) sw_raw = 16'($urandom);
                else sw_raw = sw_raw ^ (16'h1 << $urandom_range(0, 15));
                hold = $urandom_range(1, 8);
            end
            hold--;
            bus_if.addr  = 2'($urandom_range(0, 3));
            bus_if.we    = ($urandom_range(0, 3) == 0);
            bus_if.wdata = $urandom;
            #1;
            chk("rand_rdata", bus_if.rdata, model_read(bus_if.addr));
            cycle();
            bus_if.we = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
